// File: rtl/cpsr_unit.sv
// cpsr_unit: NZCV generation, one-stage pending flag register and committed CPSR.
// Optional interrupt shadow stack of the flags is built when CPSR_SHADOW_EN is defined.
module cpsr_unit #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_req,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] result,
    input  logic             stall,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [3:0]       wr_data,
    input  logic             irq_enter,
    input  logic             irq_return,
    output logic [3:0]       cpsr_out,
    output logic [3:0]       cpsr_fwd,
    output logic             flags_pending,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_ovf
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOGIC = 2'b10,
        OP_NONE  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    logic [3:0] cpsr_reg;
    logic [3:0] pend_flags;
    logic       pend_valid;
    flags_t     new_flags;
    logic       capture;
    logic       commit;
    logic       pop_ok;
    logic [3:0] pop_data;

    assign cpsr_fwd      = pend_valid ? pend_flags : cpsr_reg;
    assign cpsr_out      = cpsr_reg;
    assign flags_pending = pend_valid;

    // Carry-out of a+b is set exactly when a exceeds the headroom ~b left by b.
    always_comb begin
        // NOTE: every field gets a default before the case, so no path can infer a latch.
        new_flags = '{n: result[MSB], z: (result == '0), c: cpsr_fwd[1], v: cpsr_fwd[0]};
        case (alu_op_e'(alu_op))
            OP_ADD: begin
                new_flags.c = (op_a > ~op_b);
                new_flags.v = (op_a[MSB] == op_b[MSB]) && (result[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                new_flags.c = (op_a >= op_b);
                new_flags.v = (op_a[MSB] != op_b[MSB]) && (result[MSB] != op_a[MSB]);
            end
            default: ;
        endcase
    end

    assign capture = flag_req && !stall && !flush && (alu_op != OP_NONE);
    assign commit  = pend_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            cpsr_reg   <= 4'd0;
            pend_flags <= 4'd0;
            pend_valid <= 1'b0;
        end else begin
            if (pop_ok) begin
                cpsr_reg <= pop_data;
            end else if (wr_en) begin
                cpsr_reg <= wr_data;
            end else if (commit) begin
                cpsr_reg <= pend_flags;
            end

            // A losing commit is simply dropped: pend_valid clears unless refilled.
            if (flush) begin
                pend_valid <= 1'b0;
            end else if (!stall) begin
                pend_valid <= capture;
                if (capture) begin
                    pend_flags <= new_flags;
                end
            end
        end
    end

`ifdef CPSR_SHADOW_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [3:0]       stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]  sp;
    logic [IDX_W-1:0] top_idx;
    logic             push_req;
    logic             pop_req;
    logic             push_ok;
    logic             ovf_reg;

    assign push_req    = irq_enter && !irq_return;
    assign pop_req     = irq_return && !irq_enter;
    assign stack_full  = (sp == SP_FULL);
    assign stack_empty = (sp == '0);
    assign stack_ovf   = ovf_reg;
    assign push_ok     = push_req && !stack_full;
    assign pop_ok      = pop_req && !stack_empty;
    assign top_idx     = IDX_W'(sp - SP_W'(1));
    assign pop_data    = stack_mem[top_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp      <= '0;
            ovf_reg <= 1'b0;
        end else if (push_req) begin
            if (stack_full) begin
                ovf_reg <= 1'b1;
            end else begin
                sp <= sp + SP_W'(1);
            end
        end else if (pop_ok) begin
            sp <= sp - SP_W'(1);
        end
    end

    // NOTE: the entry array has no reset; clearing sp makes every stale entry unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            stack_mem[IDX_W'(sp)] <= cpsr_reg;
        end
    end
`else
    logic unused_irq;

    assign pop_ok      = 1'b0;
    assign pop_data    = 4'd0;
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_ovf   = 1'b0;
    assign unused_irq  = irq_enter ^ irq_return ^ (STACK_DEPTH > 0);
`endif

endmodule

// File: tb/tb_cpsr_unit.sv
// Self-checking bench for cpsr_unit: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_cpsr_unit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flag_req;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             stall;
    logic             flush;
    logic             wr_en;
    logic [3:0]       wr_data;
    logic             irq_enter;
    logic             irq_return;
    logic [3:0]       cpsr_out;
    logic [3:0]       cpsr_fwd;
    logic             flags_pending;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [3:0] m_cpsr = 4'd0;
    logic [3:0] m_pend = 4'd0;
    logic       m_pv   = 1'b0;
    logic       m_ovf  = 1'b0;
    logic [3:0] m_stack[$];

    cpsr_unit #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flag_req(flag_req), .alu_op(alu_op),
        .op_a(op_a), .op_b(op_b), .result(result), .stall(stall), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .irq_enter(irq_enter), .irq_return(irq_return),
        .cpsr_out(cpsr_out), .cpsr_fwd(cpsr_fwd), .flags_pending(flags_pending),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_ovf(stack_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flags from signed/unsigned integer arithmetic rather than bit tricks.
    function automatic logic [3:0] ref_flags(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] res,
                                             input logic [3:0] fwd);
        longint ua, ub, sa, sb, lim, half;
        logic n, z, c, v;
        lim  = longint'(1) <<< WIDTH;
        half = lim / 2;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[WIDTH-1] ? ua - lim : ua;
        sb = b[WIDTH-1] ? ub - lim : ub;
        n = res[WIDTH-1];
        z = (res == 0);
        c = fwd[1];
        v = fwd[0];
        if (op == 2'd0) begin
            c = (ua + ub) >= lim;
            v = ((sa + sb) >= half) || ((sa + sb) < -half);
        end else if (op == 2'd1) begin
            c = (ua >= ub);
            v = ((sa - sb) >= half) || ((sa - sb) < -half);
        end
        return {n, z, c, v};
    endfunction

    task automatic model_step();
        logic [3:0] fwd, nxt;
        logic       popped, cap, com;
        if (!rst_n) begin
            m_cpsr = 4'd0;
            m_pend = 4'd0;
            m_pv   = 1'b0;
            m_ovf  = 1'b0;
            m_stack.delete();
        end else begin
            fwd    = m_pv ? m_pend : m_cpsr;
            cap    = flag_req && !stall && !flush && (alu_op != 2'd3);
            com    = m_pv && !stall && !flush;
            nxt    = m_cpsr;
            popped = 1'b0;
`ifdef CPSR_SHADOW_EN
            if (irq_enter && !irq_return) begin
                if (m_stack.size() == DEPTH) m_ovf = 1'b1;
                else m_stack.push_back(m_cpsr);
            end
            if (irq_return && !irq_enter && m_stack.size() > 0) begin
                popped = 1'b1;
                nxt = m_stack.pop_back();
            end
`endif
            if (!popped) begin
                if (wr_en) nxt = wr_data;
                else if (com) nxt = m_pend;
            end
            if (flush) begin
                m_pv = 1'b0;
            end else if (!stall) begin
                if (cap) m_pend = ref_flags(alu_op, op_a, op_b, result, fwd);
                m_pv = cap;
            end
            m_cpsr = nxt;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cpsr_out", cpsr_out, m_cpsr);
            check("cpsr_fwd", cpsr_fwd, m_pv ? m_pend : m_cpsr);
            check("flags_pending", flags_pending, m_pv);
            check("stack_empty", stack_empty, m_stack.size() == 0);
            check("stack_full", stack_full, m_stack.size() == DEPTH);
            check("stack_ovf", stack_ovf, m_ovf);
        end
    end

    task automatic set_idle();
        rst_n = 1'b1; flag_req = 1'b0; alu_op = 2'd0; op_a = '0; op_b = '0; result = '0;
        stall = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = 4'd0;
        irq_enter = 1'b0; irq_return = 1'b0;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] res);
        set_idle();
        flag_req = 1'b1; alu_op = op; op_a = a; op_b = b; result = res;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        set_idle();
        rst_n = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        check("rst_out", cpsr_out, 4'd0);
        check("rst_fwd", cpsr_fwd, 4'd0);
        check("rst_pending", flags_pending, 1'b0);
        check("rst_empty", stack_empty, 1'b1);
        check("rst_full", stack_full, 1'b0);
        check("rst_ovf", stack_ovf, 1'b0);

        set_op(2'd0, 16'h7FFF, 16'h0001, 16'h8000);
        step();
        check("add_fwd_t1", cpsr_fwd, 4'b1001);
        check("add_pend_t1", flags_pending, 1'b1);
        check("add_out_t1", cpsr_out, 4'b0000);
        set_idle();
        step();
        check("add_out_t2", cpsr_out, 4'b1001);
        check("add_pend_t2", flags_pending, 1'b0);

        set_op(2'd1, 16'h0005, 16'h0005, 16'h0000);
        step();
        check("sub_fwd", cpsr_fwd, 4'b0110);
        set_op(2'd2, 16'h0000, 16'h0000, 16'hFF00);
        step();
        check("logic_fwd", cpsr_fwd, 4'b1010);
        check("sub_out", cpsr_out, 4'b0110);
        set_idle();
        step();
        check("logic_out", cpsr_out, 4'b1010);

        set_idle();
        rst_n = 1'b0;
        step();
        set_op(2'd0, 16'hFFFF, 16'h0001, 16'h0000);
        step();
        check("flush_pend_t1", flags_pending, 1'b1);
        set_idle();
        flush = 1'b1;
        step();
        check("flush_pend_t2", flags_pending, 1'b0);
        check("flush_out_t2", cpsr_out, 4'b0000);
        set_idle();
        step();
        check("flush_out_t3", cpsr_out, 4'b0000);

        set_op(2'd1, 16'h0003, 16'h0005, 16'hFFFE);
        step();
        check("stall_fwd_t1", cpsr_fwd, 4'b1000);
        set_idle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_fwd_hold", cpsr_fwd, 4'b1000);
            check("stall_out_hold", cpsr_out, 4'b0000);
        end
        set_idle();
        step();
        check("stall_out_t5", cpsr_out, 4'b1000);

        set_op(2'd1, 16'h0005, 16'h0005, 16'h0000);
        step();
        check("wp_fwd", cpsr_fwd, 4'b0110);
        set_idle();
        wr_en = 1'b1;
        wr_data = 4'b0001;
        step();
        check("wp_out", cpsr_out, 4'b0001);
        check("wp_pend", flags_pending, 1'b0);
        set_idle();
        step();
        check("wp_out_after", cpsr_out, 4'b0001);

`ifdef CPSR_SHADOW_EN
        for (int k = 1; k <= 5; k++) begin
            set_idle();
            wr_en = 1'b1;
            wr_data = 4'(k);
            step();
            set_idle();
            irq_enter = 1'b1;
            step();
            if (k == 4) begin
                check("stk_full_at4", stack_full, 1'b1);
                check("stk_ovf_at4", stack_ovf, 1'b0);
            end
        end
        check("stk_ovf", stack_ovf, 1'b1);
        check("stk_full", stack_full, 1'b1);
        for (int k = 4; k >= 1; k--) begin
            set_idle();
            irq_return = 1'b1;
            step();
            check("stk_pop", cpsr_out, 4'(k));
        end
        set_idle();
        irq_return = 1'b1;
        step();
        check("stk_pop_empty_out", cpsr_out, 4'd1);
        check("stk_pop_empty", stack_empty, 1'b1);
`else
        set_idle();
        wr_en = 1'b1;
        wr_data = 4'd7;
        step();
        set_idle();
        irq_enter = 1'b1;
        step();
        check("nostk_empty", stack_empty, 1'b1);
        check("nostk_full", stack_full, 1'b0);
        set_idle();
        irq_return = 1'b1;
        step();
        check("nostk_ret_out", cpsr_out, 4'd7);
        check("nostk_ovf", stack_ovf, 1'b0);
`endif

        set_idle();
        rst_n = 1'b0;
        step();
        for (int i = 0; i < 3000; i++) begin
            set_idle();
            rst_n    = ($urandom_range(0, 199) != 0);
            flag_req = ($urandom_range(0, 9) < 7);
            alu_op   = 2'($urandom_range(0, 3));
            op_a     = pick();
            op_b     = pick();
            if (alu_op == 2'd0) result = op_a + op_b;
            else if (alu_op == 2'd1) result = op_a - op_b;
            else result = pick();
            stall      = ($urandom_range(0, 4) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            wr_en      = ($urandom_range(0, 9) == 0);
            wr_data    = 4'($urandom);
            irq_enter  = !m_pv && ($urandom_range(0, 9) == 0);
            irq_return = ($urandom_range(0, 9) == 0);
            step();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
